// File: rtl/mul_lo_seq_pkg.sv
// Shared constants, state encoding and the RUN-termination helper for mul_lo_seq.
// The helper honours MUL_LO_EARLY_EXIT_EN (undefined by default: fixed 32-step RUN).
package mul_lo_seq_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // True when the current RUN step is the final one.
  function automatic logic run_last_step(input logic [MUL_CNT_W-1:0] cnt,
                                         input logic [MUL_WIDTH-1:0] mplier);
    logic last;
    last = (cnt == MUL_CNT_W'(MUL_WIDTH - 1));
`ifdef MUL_LO_EARLY_EXIT_EN
    // No multiplier bits left above the one consumed this step.
    last = last || ((mplier >> 1) == '0);
`else
    last = last || (mplier == '1 && 1'b0);
`endif
    return last;
  endfunction

endpackage

// File: rtl/adder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Purely combinational; carry out of bit 31 is discarded.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] w_g;
  logic [31:0] w_p;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    logic       cin;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    sum = '0;
    cin = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      g = w_g[4*k +: 4];
      p = w_p[4*k +: 4];
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      sum[4*k +: 4] = p ^ c;
      cin = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cin);
    end
  end

endmodule

// File: rtl/mul_lo_seq.sv
// Iterative 32x32 shift-add multiplier (low 32 product bits) around `adder`.
// Optional MUL_LO_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module mul_lo_seq
  import mul_lo_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  mul_state_e       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_last;

  adder u_adder (
    .a   (r_acc),
    .b   (r_mcand),
    .sum (w_sum)
  );

  assign w_acc_nxt = r_mplier[0] ? w_sum : r_acc;
  assign w_last    = run_last_step(r_cnt, r_mplier);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand    <= op_a;
            r_mplier   <= op_b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  // acc is frozen in DONE, so the result is stable for the whole handshake.
  assign result    = r_acc;

endmodule

// File: tb/tb_mul_lo_seq.sv
// Directed self-checking bench for mul_lo_seq (honours MUL_LO_EARLY_EXIT_EN if defined).
module tb_mul_lo_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  mul_lo_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, count RUN cycles, optionally stall the consumer, hand off.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int cyc_full, input int cyc_early,
                        input int hold, input bit spam);
    int n;
    int exp_cyc;
`ifdef MUL_LO_EARLY_EXIT_EN
    exp_cyc = cyc_early;
`else
    exp_cyc = cyc_full;
`endif
    out_ready = (hold == 0);
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 64) begin
      if (spam) begin
        in_valid = 1'b1;
        op_a     = 32'(n + 100);
        op_b     = 32'(n + 3);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_run_cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, "_result"}, result, exp_res);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, result, exp_res);
    end
    out_ready = 1'b1;
    step();
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    do_mul("m3x5", 32'd3, 32'd5, 32'd15, 32, 3, 0, 1'b0);
    do_mul("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 32, 0, 1'b0);
    do_mul("wrap_hi", 32'h8000_0000, 32'd2, 32'd0, 32, 2, 0, 1'b0);
    do_mul("hold", 32'h1234_5678, 32'h10, 32'h2345_6780, 32, 5, 10, 1'b0);
    do_mul("spam", 32'd11, 32'd13, 32'd143, 32, 4, 0, 1'b1);
    do_mul("b_zero", 32'hDEAD_BEEF, 32'd0, 32'd0, 32, 1, 0, 1'b0);
    do_mul("b_one", 32'd9, 32'd1, 32'd9, 32, 1, 0, 1'b0);
    do_mul("b_msb", 32'd1, 32'h8000_0000, 32'h8000_0000, 32, 32, 0, 1'b0);

    // Reset in the middle of RUN abandons the operation.
    out_ready = 1'b1;
    op_a      = 32'h0001_0001;
    op_b      = 32'hFFFF_FFFF;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_mul("after_rst", 32'd7, 32'd6, 32'd42, 32, 3, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
